// File: rtl/bsg_dramsim3_pkg.sv
// Shared DRAMSim3 types: address-mapping enum, sizing helpers, and the
// response payload struct macro (parameterised by channel/addr/data widths).

`ifndef BSG_DRAMSIM3_PKG_SV
`define BSG_DRAMSIM3_PKG_SV

// Declares a local packed struct type named dramsim3_resp_s with the given field widths.
`define BSG_DRAMSIM3_RESP_S(ch_w, addr_w, data_w) \
  typedef struct packed { \
    logic [(ch_w)-1:0]   ch; \
    logic [(addr_w)-1:0] addr; \
    logic [(data_w)-1:0] data; \
  } dramsim3_resp_s

package bsg_dramsim3_pkg;

  typedef enum logic [1:0] {
    e_ro_ra_bg_ba_co_ch = 2'd0,
    e_ro_ra_bg_ba_ch_co = 2'd1,
    e_ro_ch_ra_ba_bg_co = 2'd2
  } address_mapping_e;

  // clog2 that never returns 0, for fields that must keep at least one bit.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

endpackage

`endif

// File: rtl/bsg_dramsim3_addr_map.sv
// Rebuilds a global memory address from a channel-local address and the
// channel index, according to the selected DRAMSim3 address mapping.
// Byte-offset bits of the result are always zero.

module bsg_dramsim3_addr_map
  import bsg_dramsim3_pkg::*;
#(
  parameter int unsigned channel_addr_width_p = 32,
  parameter int unsigned data_width_p         = 512,
  parameter int unsigned num_channels_p       = 2,
  parameter int unsigned num_columns_p        = 1024,
  parameter int unsigned num_ba_p             = 4,
  parameter int unsigned num_bg_p             = 4,
  parameter int unsigned num_ranks_p          = 1,
  parameter address_mapping_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  localparam int unsigned lg_num_channels_lp  = $clog2(num_channels_p),
  localparam int unsigned ch_width_lp         = (lg_num_channels_lp == 0) ? 1 : lg_num_channels_lp,
  localparam int unsigned addr_width_lp       = lg_num_channels_lp + channel_addr_width_p
)(
  input  logic [channel_addr_width_p-1:0] ch_addr,
  input  logic [ch_width_lp-1:0]          ch,
  output logic [addr_width_lp-1:0]        addr
);

  localparam int unsigned bo_lp  = safe_clog2(data_width_p >> 3);
  localparam int unsigned lc_lp  = $clog2(num_columns_p);
  localparam int unsigned lba_lp = $clog2(num_ba_p);
  localparam int unsigned lbg_lp = $clog2(num_bg_p);
  localparam int unsigned lra_lp = $clog2(num_ranks_p);
  // Channel-local field positions for the {ro,ra,bg,ba,co,bo} layout.
  localparam int unsigned ba_pos_lp = bo_lp + lc_lp;
  localparam int unsigned bg_pos_lp = ba_pos_lp + lba_lp;
  localparam int unsigned ro_pos_lp = bg_pos_lp + lbg_lp + lra_lp;

  typedef logic [addr_width_lp-1:0] addr_t;

  if (!((address_mapping_p == e_ro_ra_bg_ba_co_ch)
     || (address_mapping_p == e_ro_ra_bg_ba_ch_co)
     || (address_mapping_p == e_ro_ch_ra_ba_bg_co))) begin : g_bad_map
    $fatal(1, "bsg_dramsim3_addr_map: unsupported address_mapping_p");
  end

  if (channel_addr_width_p < ro_pos_lp) begin : g_bad_width
    $fatal(1, "bsg_dramsim3_addr_map: channel_addr_width_p too small for geometry");
  end

  function automatic addr_t low_mask(input int unsigned w);
    return (addr_t'(1) << w) - addr_t'(1);
  endfunction

  function automatic addr_t field(input addr_t x, input int unsigned lsb, input int unsigned w);
    return (x >> lsb) & low_mask(w);
  endfunction

  // Opens a gap of lg_num_channels_lp bits at pos and drops the channel index into it.
  function automatic addr_t insert_ch(input addr_t x, input addr_t c, input int unsigned pos);
    addr_t m;
    m = low_mask(pos);
    return ((x & ~m) << lg_num_channels_lp) | (c << pos) | (x & m);
  endfunction

  addr_t ext;
  addr_t chx;
  addr_t swapped;

  // Mask off byte offset, then place the channel index per mapping.
  always_comb begin
    ext     = addr_t'(ch_addr) & ~low_mask(bo_lp);
    chx     = (lg_num_channels_lp == 0) ? '0 : addr_t'(ch);
    swapped = (ext & ~(low_mask(lba_lp + lbg_lp) << ba_pos_lp))
            | (field(ext, ba_pos_lp, lba_lp) << (ba_pos_lp + lbg_lp))
            | (field(ext, bg_pos_lp, lbg_lp) << ba_pos_lp);
    addr    = '0;
    case (address_mapping_p)
      e_ro_ra_bg_ba_co_ch: addr = insert_ch(ext, chx, bo_lp);
      e_ro_ra_bg_ba_ch_co: addr = insert_ch(ext, chx, bo_lp + lc_lp);
      e_ro_ch_ra_ba_bg_co: addr = insert_ch(swapped, chx, ro_pos_lp);
      default:             addr = '0;
    endcase
  end

endmodule

// File: rtl/bsg_nonsynth_dramsim3_map_resp.sv
// Merges per-channel DRAMSim3 read responses into one stream through a
// round-robin arbiter and a 2-entry output FIFO, rebuilding global addresses.
// Optional checks: define BSG_DRAMSIM3_MAP_RESP_CHECK_EN to flag misaligned
// channel addresses and valids that drop before being consumed.

module bsg_nonsynth_dramsim3_map_resp
  import bsg_dramsim3_pkg::*;
#(
  parameter int unsigned channel_addr_width_p = 32,
  parameter int unsigned data_width_p         = 512,
  parameter int unsigned num_channels_p       = 2,
  parameter int unsigned num_columns_p        = 1024,
  parameter int unsigned num_rows_p           = 2048,
  parameter int unsigned num_ba_p             = 4,
  parameter int unsigned num_bg_p             = 4,
  parameter int unsigned num_ranks_p          = 1,
  parameter address_mapping_e address_mapping_p = e_ro_ra_bg_ba_co_ch,
  localparam int unsigned lg_num_channels_lp  = $clog2(num_channels_p),
  localparam int unsigned ch_width_lp         = (lg_num_channels_lp == 0) ? 1 : lg_num_channels_lp,
  localparam int unsigned addr_width_lp       = lg_num_channels_lp + channel_addr_width_p
)(
  input  logic                                                clk_i,
  input  logic                                                reset_n_i,
  input  logic [num_channels_p-1:0]                           v_i,
  input  logic [num_channels_p-1:0][channel_addr_width_p-1:0] ch_addr_i,
  input  logic [num_channels_p-1:0][data_width_p-1:0]         data_i,
  output logic [num_channels_p-1:0]                           yumi_o,
  output logic                                                v_o,
  output logic [ch_width_lp-1:0]                              ch_o,
  output logic [addr_width_lp-1:0]                            addr_o,
  output logic [data_width_p-1:0]                             data_o,
  input  logic                                                ready_i
);

  `BSG_DRAMSIM3_RESP_S(ch_width_lp, addr_width_lp, data_width_p);

  localparam int unsigned fifo_depth_lp = 2;

  if (num_channels_p < 1) begin : g_bad_channels
    $fatal(1, "bsg_nonsynth_dramsim3_map_resp: num_channels_p must be >= 1");
  end

  if (!(is_pow2(num_columns_p) && is_pow2(num_rows_p) && is_pow2(num_ba_p)
     && is_pow2(num_bg_p) && is_pow2(num_ranks_p))) begin : g_bad_geom
    $fatal(1, "bsg_nonsynth_dramsim3_map_resp: DRAM geometry must be powers of 2");
  end

  if ((data_width_p == 0) || ((data_width_p % 8) != 0)) begin : g_bad_data
    $fatal(1, "bsg_nonsynth_dramsim3_map_resp: data_width_p must be a multiple of 8");
  end

  logic [ch_width_lp-1:0]          rr_ptr_r, rr_ptr_n;
  logic [1:0]                      count_r;
  logic                            wr_ptr_r, rd_ptr_r;
  dramsim3_resp_s                  mem_r [fifo_depth_lp];
  dramsim3_resp_s                  enq_entry, head;
  logic                            full, grant_v, deq;
  logic [ch_width_lp-1:0]          grant_ch, hi_ch, lo_ch;
  logic                            hi_v, lo_v;
  logic [channel_addr_width_p-1:0] grant_addr;
  logic [addr_width_lp-1:0]        mapped_addr;

  assign full = (count_r == 2'(fifo_depth_lp));

  // Round-robin pick: lowest requester at/after rr_ptr_r, else lowest overall.
  always_comb begin
    hi_v  = 1'b0;
    lo_v  = 1'b0;
    hi_ch = '0;
    lo_ch = '0;
    for (int i = int'(num_channels_p) - 1; i >= 0; i--) begin
      if (v_i[i]) begin
        lo_v  = 1'b1;
        lo_ch = ch_width_lp'(i);
        if (i >= int'(rr_ptr_r)) begin
          hi_v  = 1'b1;
          hi_ch = ch_width_lp'(i);
        end
      end
    end
    grant_ch = hi_v ? hi_ch : lo_ch;
    grant_v  = lo_v & ~full & reset_n_i;
  end

  // Next priority pointer: the channel after the one just granted.
  always_comb begin
    rr_ptr_n = rr_ptr_r;
    if (grant_v) begin
      if (32'(grant_ch) + 32'd1 >= num_channels_p) rr_ptr_n = '0;
      else                                         rr_ptr_n = grant_ch + ch_width_lp'(1);
    end
  end

  // One-hot consume strobe for the granted channel.
  always_comb begin
    yumi_o = '0;
    if (grant_v) yumi_o[grant_ch] = 1'b1;
  end

  assign grant_addr = ch_addr_i[grant_ch];

  bsg_dramsim3_addr_map #(
    .channel_addr_width_p(channel_addr_width_p),
    .data_width_p        (data_width_p),
    .num_channels_p      (num_channels_p),
    .num_columns_p       (num_columns_p),
    .num_ba_p            (num_ba_p),
    .num_bg_p            (num_bg_p),
    .num_ranks_p         (num_ranks_p),
    .address_mapping_p   (address_mapping_p)
  ) u_addr_map (
    .ch_addr(grant_addr),
    .ch     (grant_ch),
    .addr   (mapped_addr)
  );

  // Assemble the entry written on grant.
  always_comb begin
    enq_entry      = '0;
    enq_entry.ch   = grant_ch;
    enq_entry.addr = mapped_addr;
    enq_entry.data = data_i[grant_ch];
  end

  assign head   = mem_r[rd_ptr_r];
  assign v_o    = (count_r != 2'd0) & reset_n_i;
  assign deq    = v_o & ready_i;
  assign ch_o   = head.ch;
  assign addr_o = head.addr;
  assign data_o = head.data;

  // FIFO occupancy, pointers and arbiter priority.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      rr_ptr_r <= '0;
    end else begin
      count_r  <= count_r + 2'(grant_v) - 2'(deq);
      rr_ptr_r <= rr_ptr_n;
      if (grant_v) wr_ptr_r <= ~wr_ptr_r;
      if (deq)     rd_ptr_r <= ~rd_ptr_r;
    end
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (grant_v) mem_r[wr_ptr_r] <= enq_entry;
  end

`ifdef BSG_DRAMSIM3_MAP_RESP_CHECK_EN
  localparam int unsigned byte_offset_width_lp = safe_clog2(data_width_p >> 3);
  logic [num_channels_p-1:0] waiting_r;

  // Flag misaligned granted addresses and requests withdrawn while pending.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      waiting_r <= '0;
    end else begin
      waiting_r <= v_i & ~yumi_o;
      if (grant_v && (grant_addr[byte_offset_width_lp-1:0] != '0))
        $error("bsg_nonsynth_dramsim3_map_resp: ch %0d addr %h has nonzero byte offset",
               grant_ch, grant_addr);
      if ((waiting_r & ~v_i) != '0)
        $error("bsg_nonsynth_dramsim3_map_resp: v_i dropped while waiting (%b)",
               waiting_r & ~v_i);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_map_resp.sv
// Directed bench: three instances share stimulus, one per address mapping.

module tb_bsg_nonsynth_dramsim3_map_resp;
  import bsg_dramsim3_pkg::*;

  localparam int unsigned CW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned NC = 2;
  localparam int unsigned AW = 33;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NC-1:0]          v_in;
  logic [NC-1:0][CW-1:0]  ch_addr_in;
  logic [NC-1:0][DW-1:0]  data_in;
  logic                   ready;

  logic [NC-1:0] yumi [3];
  logic          v    [3];
  logic          ch   [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] dout [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bsg_nonsynth_dramsim3_map_resp #(
    .channel_addr_width_p(CW), .data_width_p(DW), .num_channels_p(NC),
    .num_columns_p(1024), .num_rows_p(2048), .num_ba_p(4), .num_bg_p(4), .num_ranks_p(2),
    .address_mapping_p(e_ro_ra_bg_ba_co_ch)
  ) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .ch_addr_i(ch_addr_in), .data_i(data_in),
    .yumi_o(yumi[0]), .v_o(v[0]), .ch_o(ch[0]), .addr_o(addr[0]), .data_o(dout[0]), .ready_i(ready)
  );

  bsg_nonsynth_dramsim3_map_resp #(
    .channel_addr_width_p(CW), .data_width_p(DW), .num_channels_p(NC),
    .num_columns_p(1024), .num_rows_p(2048), .num_ba_p(4), .num_bg_p(4), .num_ranks_p(2),
    .address_mapping_p(e_ro_ra_bg_ba_ch_co)
  ) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .ch_addr_i(ch_addr_in), .data_i(data_in),
    .yumi_o(yumi[1]), .v_o(v[1]), .ch_o(ch[1]), .addr_o(addr[1]), .data_o(dout[1]), .ready_i(ready)
  );

  bsg_nonsynth_dramsim3_map_resp #(
    .channel_addr_width_p(CW), .data_width_p(DW), .num_channels_p(NC),
    .num_columns_p(1024), .num_rows_p(2048), .num_ba_p(4), .num_bg_p(4), .num_ranks_p(2),
    .address_mapping_p(e_ro_ch_ra_ba_bg_co)
  ) u_dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_in), .ch_addr_i(ch_addr_in), .data_i(data_in),
    .yumi_o(yumi[2]), .v_o(v[2]), .ch_o(ch[2]), .addr_o(addr[2]), .data_o(dout[2]), .ready_i(ready)
  );

  function automatic logic [DW-1:0] pat(input int n);
    return {16{32'h5A5A_0000 | 32'(n)}};
  endfunction

  // Present one response on channel c for a single cycle; returns #1 after the next negedge.
  task automatic drive_one(input logic c, input logic [CW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    v_in = NC'(1) << c;
    ch_addr_in[c] = a;
    data_in[c] = d;
    @(negedge clk);
    v_in = '0;
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; v_in = 2'b11; ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_v dut%0d got %b want 0", k, v[k]); end
      n_tests++; if (yumi[k] !== 2'b00) begin n_fail++; $display("FAIL reset_yumi dut%0d got %b want 00", k, yumi[k]); end
    end
    @(negedge clk);
    reset_n = 1'b1; v_in = '0;
  endtask

  task automatic test_single;
    @(negedge clk);
    v_in = 2'b10; ch_addr_in[1] = 32'h40; data_in[1] = pat(1);
    #1;
    n_tests++; if (yumi[0] !== 2'b10) begin n_fail++; $display("FAIL single_yumi got %b want 10", yumi[0]); end
    n_tests++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL single_v_early got %b want 0", v[0]); end
    @(negedge clk);
    v_in = '0; #1;
    n_tests++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL single_v got %b want 1", v[0]); end
    n_tests++; if (ch[0] !== 1'b1) begin n_fail++; $display("FAIL single_ch got %b want 1", ch[0]); end
    n_tests++; if (addr[0] !== 33'h0C0) begin n_fail++; $display("FAIL single_addr got %h want 0c0", addr[0]); end
    n_tests++; if (dout[0] !== pat(1)) begin n_fail++; $display("FAIL single_data got %h want %h", dout[0], pat(1)); end
    @(negedge clk); #1;
    n_tests++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", v[0]); end
  endtask

  task automatic test_map;
    drive_one(1'b1, 32'h0001_0040, pat(2));
    n_tests++; if (addr[1] !== 33'h3_0040) begin n_fail++; $display("FAIL ch_co_ch1 got %h want 30040", addr[1]); end
    n_tests++; if (addr[0] !== 33'h2_00C0) begin n_fail++; $display("FAIL co_ch_ch1 got %h want 200c0", addr[0]); end
    n_tests++; if (ch[1] !== 1'b1) begin n_fail++; $display("FAIL ch_co_chid got %b want 1", ch[1]); end
    drive_one(1'b0, 32'h0001_0040, pat(3));
    n_tests++; if (addr[1] !== 33'h2_0040) begin n_fail++; $display("FAIL ch_co_ch0 got %h want 20040", addr[1]); end
    n_tests++; if (dout[1] !== pat(3)) begin n_fail++; $display("FAIL ch_co_data got %h want %h", dout[1], pat(3)); end
    drive_one(1'b0, 32'h00B9_00C0, pat(4));
    n_tests++; if (addr[2] !== 33'h156_00C0) begin n_fail++; $display("FAIL ro_ch_ch0 got %h want 15600c0", addr[2]); end
    drive_one(1'b1, 32'h00B9_00C0, pat(5));
    n_tests++; if (addr[2] !== 33'h176_00C0) begin n_fail++; $display("FAIL ro_ch_ch1 got %h want 17600c0", addr[2]); end
    n_tests++; if (ch[2] !== 1'b1) begin n_fail++; $display("FAIL ro_ch_chid got %b want 1", ch[2]); end
  endtask

  task automatic test_low_bits;
    drive_one(1'b1, 32'h0000_1041, pat(6));
    n_tests++; if (addr[0] !== 33'h20C0) begin n_fail++; $display("FAIL lowbits_co_ch got %h want 20c0", addr[0]); end
    n_tests++; if (addr[1] !== 33'h1_1040) begin n_fail++; $display("FAIL lowbits_ch_co got %h want 11040", addr[1]); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_yumi;
    logic       exp_ch;
    @(negedge clk);
    v_in = 2'b11; ready = 1'b1;
    ch_addr_in[0] = 32'h80; ch_addr_in[1] = 32'h80;
    data_in[0] = pat(10); data_in[1] = pat(11);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) v_in = 2'b10;
      #1;
      exp_yumi = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_tests++; if (yumi[0] !== exp_yumi) begin n_fail++; $display("FAIL b2b_yumi c%0d got %b want %b", k, yumi[0], exp_yumi); end
      if (k == 0) begin
        n_tests++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_v c0 got %b want 0", v[0]); end
      end else begin
        exp_ch = ((k - 1) % 2) != 0;
        n_tests++; if (v[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_v c%0d got %b want 1", k, v[0]); end
        n_tests++; if (ch[0] !== exp_ch) begin n_fail++; $display("FAIL b2b_ch c%0d got %b want %b", k, ch[0], exp_ch); end
        n_tests++; if (addr[0] !== (exp_ch ? 33'h140 : 33'h100)) begin n_fail++; $display("FAIL b2b_addr c%0d got %h", k, addr[0]); end
      end
      @(negedge clk);
    end
    v_in = '0; #1;
    n_tests++; if (v[0] !== 1'b1 || ch[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_last got v=%b ch=%b want v=1 ch=1", v[0], ch[0]); end
    n_tests++; if (dout[0] !== pat(11)) begin n_fail++; $display("FAIL b2b_last_data got %h want %h", dout[0], pat(11)); end
    @(negedge clk); #1;
    n_tests++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", v[0]); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    ready = 1'b0; v_in = 2'b11;
    ch_addr_in[0] = 32'h200; ch_addr_in[1] = 32'h200;
    data_in[0] = pat(20); data_in[1] = pat(21);
    #1;
    n_tests++; if (yumi[0] !== 2'b01) begin n_fail++; $display("FAIL stall_yumi c0 got %b want 01", yumi[0]); end
    @(negedge clk);
    data_in[0] = pat(22); #1;
    n_tests++; if (yumi[0] !== 2'b10) begin n_fail++; $display("FAIL stall_yumi c1 got %b want 10", yumi[0]); end
    n_tests++; if (v[0] !== 1'b1 || ch[0] !== 1'b0 || dout[0] !== pat(20)) begin n_fail++; $display("FAIL stall_head c1 got v=%b ch=%b", v[0], ch[0]); end
    @(negedge clk);
    v_in = 2'b01; #1;
    n_tests++; if (yumi[0] !== 2'b00) begin n_fail++; $display("FAIL stall_full c2 got %b want 00", yumi[0]); end
    n_tests++; if (ch[0] !== 1'b0 || dout[0] !== pat(20) || addr[0] !== 33'h400) begin n_fail++; $display("FAIL stall_stable c2 got ch=%b addr=%h", ch[0], addr[0]); end
    @(negedge clk);
    ready = 1'b1; #1;
    n_tests++; if (yumi[0] !== 2'b00) begin n_fail++; $display("FAIL stall_nofallthru got %b want 00", yumi[0]); end
    n_tests++; if (dout[0] !== pat(20)) begin n_fail++; $display("FAIL stall_stable c3 got %h want %h", dout[0], pat(20)); end
    @(negedge clk); #1;
    n_tests++; if (yumi[0] !== 2'b01) begin n_fail++; $display("FAIL stall_third_grant got %b want 01", yumi[0]); end
    n_tests++; if (ch[0] !== 1'b1 || addr[0] !== 33'h440 || dout[0] !== pat(21)) begin n_fail++; $display("FAIL stall_order2 got ch=%b addr=%h", ch[0], addr[0]); end
    @(negedge clk);
    v_in = '0; #1;
    n_tests++; if (v[0] !== 1'b1 || ch[0] !== 1'b0 || dout[0] !== pat(22)) begin n_fail++; $display("FAIL stall_order3 got v=%b ch=%b", v[0], ch[0]); end
    @(negedge clk); #1;
    n_tests++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %b want 0", v[0]); end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    ready = 1'b0; v_in = 2'b11; data_in[0] = pat(30); data_in[1] = pat(31);
    #1;
    n_tests++; if (yumi[0] !== 2'b10) begin n_fail++; $display("FAIL rst_pre_yumi got %b want 10", yumi[0]); end
    @(negedge clk);
    v_in = 2'b01;
    @(negedge clk);
    v_in = 2'b11; reset_n = 1'b0; #1;
    n_tests++; if (v[0] !== 1'b0 || yumi[0] !== 2'b00) begin n_fail++; $display("FAIL rst_in_reset got v=%b yumi=%b want 0 00", v[0], yumi[0]); end
    @(negedge clk);
    reset_n = 1'b1; #1;
    n_tests++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_flushed got v=%b want 0", v[0]); end
    n_tests++; if (yumi[0] !== 2'b01) begin n_fail++; $display("FAIL rst_ptr got yumi=%b want 01", yumi[0]); end
    @(negedge clk);
    v_in = '0; ready = 1'b1; #1;
    n_tests++; if (v[0] !== 1'b1 || ch[0] !== 1'b0 || dout[0] !== pat(30)) begin n_fail++; $display("FAIL rst_post got v=%b ch=%b", v[0], ch[0]); end
    @(negedge clk); #1;
    n_tests++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL rst_drain got %b want 0", v[0]); end
  endtask

  initial begin
    reset_n = 1'b0; v_in = '0; ready = 1'b1; ch_addr_in = '0; data_in = '0;
    test_reset();
    test_single();
    test_map();
`ifndef BSG_DRAMSIM3_MAP_RESP_CHECK_EN
    test_low_bits();
`endif
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
